// File: rtl/dmem_pkg.sv
// dmem_pkg: shared definitions for the data-memory arbiter.
//   - write-size codes carried on the *_we / mem_we buses
//   - arbiter FSM state encoding
//   - owner ids for the two requesting ports
package dmem_pkg;

  localparam logic [1:0] NO_WRITE   = 2'b00;
  localparam logic [1:0] WORD_WRITE = 2'b01;
  localparam logic [1:0] HALF_WRITE = 2'b10;
  localparam logic [1:0] BYTE_WRITE = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    RESP   = 2'b10
  } state_t;

  localparam logic OWN_C = 1'b0;
  localparam logic OWN_D = 1'b1;

endpackage

// File: rtl/dmem_align_chk.sv
// dmem_align_chk: combinational legality check for one memory access.
// Ports:
//   we    in  2   write-size code (00 read, 01 word, 10 half, 11 byte)
//   addr  in  AW  byte address
//   err   out 1   access is misaligned for its size or beyond DEPTH_WORDS
module dmem_align_chk
  import dmem_pkg::*;
#(
  parameter int AW          = 32,
  parameter int DEPTH_WORDS = 64
) (
  input  logic [1:0]    we,
  input  logic [AW-1:0] addr,
  output logic          err
);

  logic misalign_s;
  logic range_s;

  // Alignment requirement depends on the access size; reads are word sized.
  always_comb begin
    misalign_s = 1'b0;
    case (we)
      NO_WRITE:   misalign_s = (addr[1:0] != 2'b00);
      WORD_WRITE: misalign_s = (addr[1:0] != 2'b00);
      HALF_WRITE: misalign_s = addr[0];
      BYTE_WRITE: misalign_s = 1'b0;
      default:    misalign_s = 1'b1;
    endcase
  end

  assign range_s = (addr[AW-1:2] >= (AW-2)'(DEPTH_WORDS));
  assign err     = misalign_s | range_s;

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares a single-port data memory between the core MEM stage
// (port C) and a debug/loader port (port D). One access in flight at a time:
// grant in cycle N, memory access in N+1, one-cycle response pulse in N+2.
// Misaligned or out-of-range accesses never write memory and read back 0.
// Ports:
//   clk, reset                      clock, async active-high reset
//   c_req/c_we/c_addr/c_wdata       core request (held until c_gnt)
//   c_gnt/c_rvalid/c_rdata/c_err    core grant and response
//   d_*                             same set for the debug/loader port
//   mem_addr/mem_wdata/mem_we       drive to data memory (mem_we 00 = no write)
//   mem_rdata                       combinational read word from data memory
// Build option: DMEM_ARB_RR_EN selects round-robin arbitration; when it is
// undefined the core port has fixed priority.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int DEPTH_WORDS = 64
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          c_req,
  input  logic [1:0]    c_we,
  input  logic [AW-1:0] c_addr,
  input  logic [DW-1:0] c_wdata,
  output logic          c_gnt,
  output logic          c_rvalid,
  output logic [DW-1:0] c_rdata,
  output logic          c_err,
  input  logic          d_req,
  input  logic [1:0]    d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  output logic          d_err,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic [1:0]    mem_we,
  input  logic [DW-1:0] mem_rdata
);

  state_t        state_r, state_s;
  logic          can_gnt_s, c_win_s, d_win_s, any_gnt_s;
  logic [1:0]    sel_we_s;
  logic [AW-1:0] sel_addr_s;
  logic [DW-1:0] sel_wdata_s;
  logic          sel_err_s;
  logic          owner_r, err_r;
  logic [AW-1:0] addr_r;
  logic [DW-1:0] wdata_r;
  logic [1:0]    mem_we_r;
  logic [DW-1:0] resp_data_s;
  logic          c_rvalid_r, d_rvalid_r, c_err_r, d_err_r;
  logic [DW-1:0] c_rdata_r, d_rdata_r;

  // Reset also masks grants so every output reads 0 while it is held.
  assign can_gnt_s = ~reset & ((state_r == IDLE) | (state_r == RESP));

`ifdef DMEM_ARB_RR_EN
  logic prio_r;  // port that wins the next tie

  // Tie-break by pointer; a lone requester always wins.
  always_comb begin
    c_win_s = 1'b0;
    d_win_s = 1'b0;
    if (c_req && d_req) begin
      c_win_s = (prio_r == OWN_C);
      d_win_s = (prio_r == OWN_D);
    end else begin
      c_win_s = c_req;
      d_win_s = d_req;
    end
  end

  // Hand tie priority to the port that was not just granted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prio_r <= OWN_C;
    end else if (c_gnt) begin
      prio_r <= OWN_D;
    end else if (d_gnt) begin
      prio_r <= OWN_C;
    end else begin
      prio_r <= prio_r;
    end
  end
`else
  // Fixed priority: the core always beats the debug port.
  always_comb begin
    c_win_s = c_req;
    d_win_s = d_req & ~c_req;
  end
`endif

  assign c_gnt     = can_gnt_s & c_win_s;
  assign d_gnt     = can_gnt_s & d_win_s;
  assign any_gnt_s = c_gnt | d_gnt;

  assign sel_we_s    = d_gnt ? d_we    : c_we;
  assign sel_addr_s  = d_gnt ? d_addr  : c_addr;
  assign sel_wdata_s = d_gnt ? d_wdata : c_wdata;

  dmem_align_chk #(
    .AW          (AW),
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_align_chk (
    .we   (sel_we_s),
    .addr (sel_addr_s),
    .err  (sel_err_s)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next state: ACCESS always lasts one cycle; RESP may overlap a new grant.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE:    state_s = any_gnt_s ? ACCESS : IDLE;
      ACCESS:  state_s = RESP;
      RESP:    state_s = any_gnt_s ? ACCESS : IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Latch the winning request. addr/wdata double as the memory drive, so they
  // naturally hold their last values outside ACCESS. The write strobe is only
  // set for the single ACCESS cycle and is suppressed for illegal accesses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner_r  <= OWN_C;
      addr_r   <= {AW{1'b0}};
      wdata_r  <= {DW{1'b0}};
      err_r    <= 1'b0;
      mem_we_r <= NO_WRITE;
    end else if (any_gnt_s) begin
      owner_r  <= d_gnt ? OWN_D : OWN_C;
      addr_r   <= sel_addr_s;
      wdata_r  <= sel_wdata_s;
      err_r    <= sel_err_s;
      mem_we_r <= sel_err_s ? NO_WRITE : sel_we_s;
    end else begin
      mem_we_r <= NO_WRITE;
    end
  end

  assign resp_data_s = err_r ? {DW{1'b0}} : mem_rdata;

  // Capture the memory result at the end of ACCESS into the owner's response.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      c_rvalid_r <= 1'b0;
      c_rdata_r  <= {DW{1'b0}};
      c_err_r    <= 1'b0;
      d_rvalid_r <= 1'b0;
      d_rdata_r  <= {DW{1'b0}};
      d_err_r    <= 1'b0;
    end else if (state_r == ACCESS) begin
      c_rvalid_r <= (owner_r == OWN_C);
      c_rdata_r  <= (owner_r == OWN_C) ? resp_data_s : {DW{1'b0}};
      c_err_r    <= (owner_r == OWN_C) & err_r;
      d_rvalid_r <= (owner_r == OWN_D);
      d_rdata_r  <= (owner_r == OWN_D) ? resp_data_s : {DW{1'b0}};
      d_err_r    <= (owner_r == OWN_D) & err_r;
    end else begin
      c_rvalid_r <= 1'b0;
      c_rdata_r  <= {DW{1'b0}};
      c_err_r    <= 1'b0;
      d_rvalid_r <= 1'b0;
      d_rdata_r  <= {DW{1'b0}};
      d_err_r    <= 1'b0;
    end
  end

  assign c_rvalid  = c_rvalid_r;
  assign c_rdata   = c_rdata_r;
  assign c_err     = c_err_r;
  assign d_rvalid  = d_rvalid_r;
  assign d_rdata   = d_rdata_r;
  assign d_err     = d_err_r;
  assign mem_addr  = addr_r;
  assign mem_wdata = wdata_r;
  assign mem_we    = mem_we_r;

endmodule
